// File: rtl/clk_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_ratio_monitor
// Desc     : Measures period and high time of a divided clock in i_ref_clk
//            cycles; reports ratio mismatch, lock and stalled-clock timeout.
// Revision : 1.0 - initial release
// ============================================================================
module clk_ratio_monitor #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_div_clk,
    input  logic             i_mon_en,
    input  logic [CNT_W-1:0] i_exp_ratio,
    output logic [CNT_W-1:0] o_ratio,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic             o_valid,
    output logic             o_mismatch,
    output logic             o_lock,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0]     C_CNT_MAX   = {CNT_W{1'b1}};
    localparam int                   C_MATCH_W   = $clog2(LOCK_N) + 1;
    localparam logic [C_MATCH_W-1:0] C_MATCH_TGT = C_MATCH_W'(LOCK_N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_high;
    logic [CNT_W-1:0]     r_prev;
    logic [C_MATCH_W-1:0] r_match;
    logic [C_MATCH_W-1:0] w_match_nxt;
    logic                 r_have_prev;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_start;
    logic                 w_capture;
    logic                 w_stall;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // i_div_clk is asynchronous: two sync stages plus one history stage
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_div_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_stall     = 1'b0;
        if (!i_mon_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    // A rise in the saturation cycle is a valid capture
                    if (w_rise) begin
                        w_capture = 1'b1;
                    end else if (r_cnt == C_CNT_MAX) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_ARM;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // First capture after arming only seeds the comparison value
    always_comb begin
        w_match_nxt = '0;
        if (r_have_prev && (r_cnt == r_prev)) begin
            w_match_nxt = (r_match == C_MATCH_TGT) ? r_match : r_match + C_MATCH_W'(1);
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_high      <= '0;
            r_prev      <= '0;
            r_match     <= '0;
            r_have_prev <= 1'b0;
            o_ratio     <= '0;
            o_high_cnt  <= '0;
            o_valid     <= 1'b0;
            o_mismatch  <= 1'b0;
            o_lock      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_valid <= w_capture;
            if (!i_mon_en) begin
                r_cnt       <= '0;
                r_match     <= '0;
                r_have_prev <= 1'b0;
                o_mismatch  <= 1'b0;
                o_lock      <= 1'b0;
                o_timeout   <= 1'b0;
            end else begin
                if (w_start || w_capture) begin
                    r_cnt <= CNT_W'(1);
                end else if (w_stall || (r_state == S_IDLE)) begin
                    r_cnt <= '0;
                end else if ((r_state == S_MEASURE) && (r_cnt != C_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end

                if ((r_state == S_MEASURE) && w_fall) begin
                    r_high <= r_cnt;
                end

                if (w_capture) begin
                    o_ratio     <= r_cnt;
                    o_high_cnt  <= r_high;
                    o_mismatch  <= (r_cnt != i_exp_ratio);
                    r_prev      <= r_cnt;
                    r_have_prev <= 1'b1;
                    r_match     <= w_match_nxt;
                    o_lock      <= (w_match_nxt == C_MATCH_TGT);
                end

                if (w_stall) begin
                    o_timeout   <= 1'b1;
                    o_lock      <= 1'b0;
                    r_match     <= '0;
                    r_have_prev <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
